// File: rtl/regfile_fwd_pkg.sv
// Shared widths, enable levels and bypass-source encoding for the forwarding register file.
package regfile_fwd_pkg;

    localparam int REG_BUS      = 32;
    localparam int REG_ADDR_BUS = 5;
    localparam int REG_NUM      = 32;

    localparam logic RST_ENABLE   = 1'b1;
    localparam logic WRITE_ENABLE = 1'b1;
    localparam logic READ_ENABLE  = 1'b1;

    localparam logic [REG_BUS-1:0]      ZERO_WORD    = '0;
    localparam logic [REG_ADDR_BUS-1:0] NOP_REG_ADDR = '0;

    // Which producer supplies a read port, youngest first.
    typedef enum logic [2:0] {
        SRC_ZERO,
        SRC_EX,
        SRC_MEM,
        SRC_WB,
        SRC_ARRAY
    } bypass_src_e;

endpackage

// File: rtl/regfile_bypass_mux.sv
// Per-read-port priority chain: zero / EX / MEM / WB write-through / array,
// plus the load-use hit bit for this port.
module regfile_bypass_mux
    import regfile_fwd_pkg::*;
#(
    parameter int DATA_W = REG_BUS,
    parameter int ADDR_W = REG_ADDR_BUS
) (
    input  logic              rst,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    input  logic              ex_wreg,
    input  logic [ADDR_W-1:0] ex_wd,
    input  logic [DATA_W-1:0] ex_wdata,
    input  logic              ex_is_load,
    input  logic              mem_wreg,
    input  logic [ADDR_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] array_rdata,
    output logic [DATA_W-1:0] rdata,
    output logic              load_hit
);

    bypass_src_e src;

    always_comb begin
        src      = SRC_ARRAY;
        load_hit = 1'b0;
        // Zero cases are checked first so an unknown raddr never reaches the array.
        if (rst == RST_ENABLE || re != READ_ENABLE || raddr == ADDR_W'(NOP_REG_ADDR)) begin
            src = SRC_ZERO;
        end else begin
            load_hit = ex_wreg && ex_is_load && (ex_wd == raddr);
            if (ex_wreg && (ex_wd == raddr) && !ex_is_load) begin
                src = SRC_EX;
            end else if (mem_wreg && (mem_wd == raddr)) begin
                src = SRC_MEM;
            end else if (we == WRITE_ENABLE && (waddr == raddr)) begin
                src = SRC_WB;
            end
        end
    end

    always_comb begin
        rdata = DATA_W'(ZERO_WORD);
        unique case (src)
            SRC_EX:    rdata = ex_wdata;
            SRC_MEM:   rdata = mem_wdata;
            SRC_WB:    rdata = wdata;
            SRC_ARRAY: rdata = array_rdata;
            default:   rdata = DATA_W'(ZERO_WORD);
        endcase
    end

endmodule

// File: rtl/regfile_fwd.sv
// 32x32 register file with one WB write port, two ID read ports, EX/MEM forwarding
// and a load-use stall request.
module regfile_fwd
    import regfile_fwd_pkg::*;
#(
    parameter int DATA_W   = REG_BUS,
    parameter int ADDR_W   = REG_ADDR_BUS,
    parameter int NUM_REGS = REG_NUM
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    input  logic              ex_wreg_i,
    input  logic [ADDR_W-1:0] ex_wd_i,
    input  logic [DATA_W-1:0] ex_wdata_i,
    input  logic              ex_is_load_i,
    input  logic              mem_wreg_i,
    input  logic [ADDR_W-1:0] mem_wd_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    output logic              stallreq_o
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];

    logic [DATA_W-1:0] array_rdata [2];
    logic [ADDR_W-1:0] port_raddr  [2];
    logic              port_re     [2];
    logic [DATA_W-1:0] port_rdata  [2];
    logic              port_hit    [2];

    // Register 0 is held at zero so a stray array read can never leak a value.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
            if (i != 0 && we == WRITE_ENABLE && waddr == ADDR_W'(i)) begin
                regs_d[i] = wdata;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= DATA_W'(ZERO_WORD);
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    assign port_re[0]    = re1;
    assign port_re[1]    = re2;
    assign port_raddr[0] = raddr1;
    assign port_raddr[1] = raddr2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            assign array_rdata[gi] = regs_q[port_raddr[gi]];

            regfile_bypass_mux #(
                .DATA_W (DATA_W),
                .ADDR_W (ADDR_W)
            ) u_mux (
                .rst         (rst),
                .re          (port_re[gi]),
                .raddr       (port_raddr[gi]),
                .ex_wreg     (ex_wreg_i),
                .ex_wd       (ex_wd_i),
                .ex_wdata    (ex_wdata_i),
                .ex_is_load  (ex_is_load_i),
                .mem_wreg    (mem_wreg_i),
                .mem_wd      (mem_wd_i),
                .mem_wdata   (mem_wdata_i),
                .we          (we),
                .waddr       (waddr),
                .wdata       (wdata),
                .array_rdata (array_rdata[gi]),
                .rdata       (port_rdata[gi]),
                .load_hit    (port_hit[gi])
            );
        end
    endgenerate

    assign rdata1     = port_rdata[0];
    assign rdata2     = port_rdata[1];
    assign stallreq_o = port_hit[0] | port_hit[1];

endmodule

// File: tb/tb_regfile_fwd.sv
// Directed bench for regfile_fwd: expectations queued as stimulus is applied,
// then popped and compared once the combinational outputs settle.
module tb_regfile_fwd;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        re1, re2;
    logic [4:0]  raddr1, raddr2;
    logic [31:0] rdata1, rdata2;
    logic        ex_wreg_i, ex_is_load_i;
    logic [4:0]  ex_wd_i;
    logic [31:0] ex_wdata_i;
    logic        mem_wreg_i;
    logic [4:0]  mem_wd_i;
    logic [31:0] mem_wdata_i;
    logic        stallreq_o;

    regfile_fwd dut (
        .clk          (clk),
        .rst          (rst),
        .we           (we),
        .waddr        (waddr),
        .wdata        (wdata),
        .re1          (re1),
        .raddr1       (raddr1),
        .rdata1       (rdata1),
        .re2          (re2),
        .raddr2       (raddr2),
        .rdata2       (rdata2),
        .ex_wreg_i    (ex_wreg_i),
        .ex_wd_i      (ex_wd_i),
        .ex_wdata_i   (ex_wdata_i),
        .ex_is_load_i (ex_is_load_i),
        .mem_wreg_i   (mem_wreg_i),
        .mem_wd_i     (mem_wd_i),
        .mem_wdata_i  (mem_wdata_i),
        .stallreq_o   (stallreq_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        int          port;   // 0 = rdata1, 1 = rdata2, 2 = stallreq_o
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic push(input string tag, input int port, input logic [31:0] exp);
        exp_t e;
        e.tag  = tag;
        e.port = port;
        e.exp  = exp;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t        e;
        logic [31:0] obs;
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.port == 0)      obs = rdata1;
            else if (e.port == 1) obs = rdata2;
            else                  obs = {31'b0, stallreq_o};
            checks++;
            assert (obs === e.exp) else begin
                errors++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic idle();
        we = 0; waddr = 0; wdata = 0;
        re1 = 0; raddr1 = 0; re2 = 0; raddr2 = 0;
        ex_wreg_i = 0; ex_wd_i = 0; ex_wdata_i = 0; ex_is_load_i = 0;
        mem_wreg_i = 0; mem_wd_i = 0; mem_wdata_i = 0;
    endtask

    initial begin
        idle();
        rst = 1;

        // Reset held with writes and a live load hazard: outputs stay zero.
        repeat (4) begin
            @(negedge clk);
            we = 1; waddr = 5'($urandom_range(1, 31)); wdata = $urandom;
            re1 = 1; raddr1 = waddr; re2 = 1; raddr2 = waddr;
            ex_wreg_i = 1; ex_is_load_i = 1; ex_wd_i = waddr;
            mem_wreg_i = 1; mem_wd_i = waddr; mem_wdata_i = 32'h5555_AAAA;
            push("rst_rd1", 0, 0);
            push("rst_rd2", 1, 0);
            push("rst_stall", 2, 0);
            drain();
        end
        @(negedge clk);
        rst = 0;
        idle();
        for (int i = 0; i < 32; i++) begin
            re1 = 1; raddr1 = 5'(i);
            re2 = 1; raddr2 = 5'(31 - i);
            push($sformatf("clear_rd1_r%0d", i), 0, 0);
            push($sformatf("clear_rd2_r%0d", 31 - i), 1, 0);
            push("clear_stall", 2, 0);
            drain();
        end

        // Plain write then array read; disabled port reads zero.
        @(negedge clk);
        idle();
        we = 1; waddr = 5; wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        we = 0; re1 = 1; raddr1 = 5;
        push("r5_read", 0, 32'hDEAD_BEEF);
        drain();
        re1 = 0;
        push("r5_re_off", 0, 0);
        drain();

        // Register 0 stays zero regardless of writes or forwarding.
        @(negedge clk);
        we = 1; waddr = 0; wdata = 32'h1234_5678; re1 = 1; raddr1 = 0;
        push("r0_wb_bypass", 0, 0);
        drain();
        @(negedge clk);
        we = 0;
        push("r0_array", 0, 0);
        drain();
        ex_wreg_i = 1; ex_wd_i = 0; ex_wdata_i = 32'hCAFE_0000;
        mem_wreg_i = 1; mem_wd_i = 0; mem_wdata_i = 32'hCAFE_0001;
        push("r0_fwd", 0, 0);
        drain();

        // Forwarding priority on r7.
        @(negedge clk);
        idle();
        we = 1; waddr = 7; wdata = 32'h1;
        mem_wreg_i = 1; mem_wd_i = 7; mem_wdata_i = 32'h2;
        ex_wreg_i = 1; ex_wd_i = 7; ex_wdata_i = 32'h3;
        re1 = 1; raddr1 = 7; re2 = 1; raddr2 = 7;
        push("prio_ex_rd1", 0, 32'h3);
        push("prio_ex_rd2", 1, 32'h3);
        push("prio_ex_stall", 2, 0);
        drain();
        ex_is_load_i = 1;
        push("prio_load_rd1", 0, 32'h2);
        push("prio_load_stall", 2, 1);
        drain();
        ex_wreg_i = 0; ex_is_load_i = 0;
        push("prio_mem_rd1", 0, 32'h2);
        push("prio_mem_rd2", 1, 32'h2);
        drain();
        mem_wreg_i = 0;
        push("prio_wb_rd1", 0, 32'h1);
        push("prio_wb_rd2", 1, 32'h1);
        drain();
        @(negedge clk);
        idle();
        re1 = 1; raddr1 = 7; re2 = 1; raddr2 = 5;
        push("r7_array", 0, 32'h1);
        push("r5_array", 1, 32'hDEAD_BEEF);
        drain();

        // Load-use stall request.
        @(negedge clk);
        idle();
        ex_wreg_i = 1; ex_is_load_i = 1; ex_wd_i = 9; ex_wdata_i = 32'h0000_0099;
        re2 = 1; raddr2 = 9;
        push("lu_hit_p2", 2, 1);
        drain();
        re2 = 0;
        push("lu_re_off", 2, 0);
        drain();
        re2 = 1; raddr2 = 10;
        push("lu_other_reg", 2, 0);
        drain();
        re1 = 1; raddr1 = 9;
        push("lu_hit_p1", 2, 1);
        drain();
        ex_wd_i = 0; raddr1 = 0;
        push("lu_r0", 2, 0);
        drain();
        ex_wd_i = 9; raddr1 = 9; ex_wreg_i = 0;
        push("lu_no_wreg", 2, 0);
        drain();
        ex_wreg_i = 1; ex_is_load_i = 0;
        push("lu_not_load", 2, 0);
        push("ex_fwd_rd1", 0, 32'h0000_0099);
        drain();
        re1 = 0; raddr1 = 'x;
        push("x_addr_re_off", 0, 0);
        drain();

        // Reset arriving before the write edge cancels the write and clears the array.
        @(negedge clk);
        idle();
        we = 1; waddr = 3; wdata = 32'hAA; re1 = 1; raddr1 = 3;
        #2 rst = 1;
        push("mid_rst_rd1", 0, 0);
        push("mid_rst_stall", 2, 0);
        drain();
        @(negedge clk);
        rst = 0;
        idle();
        re1 = 1; raddr1 = 3; re2 = 1; raddr2 = 5;
        push("post_rst_r3", 0, 0);
        push("post_rst_r5", 1, 0);
        drain();
        @(negedge clk);
        we = 1; waddr = 3; wdata = 32'hAA;
        @(negedge clk);
        we = 0;
        push("rewrite_r3", 0, 32'hAA);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
